operand_fetch_stage: RTL
========================

# operand_fetch_stage

Register-file read side of the or1420 pipeline: the consumer of the write-back triple (data, index, enable) and the load-pending flag produced by the memory stage. The block holds the 32×32 general-purpose register array and serves two read ports from decode. It forwards same-cycle write-backs and returned load data, and interlocks decode on a load-use hazard until the load data arrives. It sits between decode and execute and presents registered operands to execute.

## Interface
Parameters:
- NR_OF_REGS, 32, number of architectural registers (index width fixed at 5)
- DATA_WIDTH, 32, operand and register width

Ports:
- cpuClock  in  1  single clock, all state updates on rising edge
- cpuReset  in  1  asynchronous, active-high reset
- stall  in  1  global pipeline stall; holds all outputs and state except the register-array write and load return
- rdValid  in  1  decode presents a valid read request
- rdIndexA, rdIndexB  in  5  source register indices
- wbWriteData  in  32  write-back data from the memory stage
- wbWriteIndex  in  5  write-back destination index
- wbWriteEnable  in  1  write-back enable
- wbStageLoadPending  in  1  instruction in write-back is a load whose data has not yet returned
- loadDoneValid  in  1  load data returning this cycle, for the pending load's destination
- loadData  in  32  returned load data
- operandA, operandB  out  32  registered operands to execute
- operandsValid  out  1  operands valid this cycle
- hazardStall  out  1  combinational interlock to decode/fetch
- hazardCycles  out  32  saturating count of cycles with hazardStall high

## Operation
- Register array: 32 entries; r0 reads as 0 always and is never written. The array is not reset.
- Array write port, independent of stall:
  - loadDoneValid in WAIT_LOAD writes loadData to the latched index.
  - Otherwise, wbWriteEnable writes wbWriteData to wbWriteIndex when wbStageLoadPending=0 and the index is nonzero.
- Read value per port, in priority order:
  - 0 if the index is 0.
  - Else loadData if loadDoneValid and the index matches the latched load index.
  - Else wbWriteData if wbWriteEnable, wbStageLoadPending=0 and the index matches wbWriteIndex.
  - Else the array value.
- Hazard: in IDLE, rdValid & wbStageLoadPending & wbWriteEnable & wbWriteIndex≠0 & (rdIndexA or rdIndexB = wbWriteIndex).
- FSM, two states:
  - IDLE: with no hazard and stall=0, capture operands and set operandsValid=1 next cycle. On a hazard, latch wbWriteIndex and both read indices, assert hazardStall and go to WAIT_LOAD. rdValid=0 clears operandsValid.
  - WAIT_LOAD: hazardStall=1 until loadDoneValid. When loadDoneValid arrives, hazardStall=0 that cycle, operands are captured from the latched indices with forwarding, operandsValid=1 next cycle, and the FSM returns to IDLE.
- stall=1: operands, operandsValid, state and latched indices hold. In WAIT_LOAD, loadDoneValid still writes the array but the state does not advance until stall drops. The bench holds loadDoneValid high until then.
- hazardCycles increments each cycle hazardStall=1 and saturates at 0xFFFFFFFF.

## Timing
- Reset values: operandA=0, operandB=0, operandsValid=0, hazardCycles=0, state=IDLE, latched indices=0. hazardStall=0 during and after reset.
- Read latency: 1 cycle from rdValid to operandsValid.
- Write-to-read: a write at cycle N is visible to a read issued at cycle N through forwarding.
- Load-use: hazardStall rises in the same cycle as the offending rdValid. With loadDoneValid at cycle M, operandsValid is high at M+1.
- Simultaneous write-back and load return to the same index: the load data wins for both the array and forwarding.
- Reset asserted in WAIT_LOAD: immediate return to IDLE, hazardStall=0, operandsValid=0.

## Structure
- Shared package or1420_pkg: REG_INDEX_WIDTH=5, DATA_WIDTH=32, FSM state enum (IDLE, WAIT_LOAD), R0 index constant.
- One sub-module, or1420_regArray: 32×32 array with 1 write and 2 asynchronous read ports, r0 forced to zero. Forwarding and the FSM stay in the top module.

## Test plan
- Reset, then read r0/r0 -> operandsValid=1 one cycle later, operandA=operandB=0; hazardCycles=0.
- Write r5=0xDEADBEEF, next cycle read r5/r0 -> operandA=0xDEADBEEF, operandB=0.
- Same-cycle write r7=0x12345678 and read r7/r7 -> both operands =0x12345678 one cycle later.
- Pending load to r3, read r3/r1; loadDoneValid with loadData=0xCAFEF00D after 3 cycles -> hazardStall high exactly 3 cycles, operandA=0xCAFEF00D, hazardCycles=3.
- Write attempted to r0 with 0xFFFFFFFF, then read r0 -> operand=0.
- Reset asserted mid WAIT_LOAD -> hazardStall=0 immediately, operandsValid=0, state=IDLE; a subsequent read of r0 completes normally.

Source files
------------

// File: rtl/or1420_pkg.sv
// Shared definitions for the or1420 operand fetch slice.
package or1420_pkg;

  localparam int REG_INDEX_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam logic [REG_INDEX_WIDTH-1:0] R0 = '0;

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } of_state_e;

endpackage

// File: rtl/or1420_regArray.sv
// General-purpose register array: one write port, two async reads.
module or1420_regArray #(
  parameter int NR_OF_REGS = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  cpuClock,
  input  logic                  writeEnable,
  input  logic [4:0]            writeIndex,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [4:0]            readIndexA,
  input  logic [4:0]            readIndexB,
  output logic [DATA_WIDTH-1:0] readDataA,
  output logic [DATA_WIDTH-1:0] readDataB
);
  import or1420_pkg::*;

  logic [DATA_WIDTH-1:0] regs [NR_OF_REGS];

  // Storage is deliberately left without reset.
  always_ff @(posedge cpuClock) begin
    if (writeEnable && writeIndex != R0)
      regs[writeIndex] <= writeData;
  end

  assign readDataA = (readIndexA == R0) ? '0 : regs[readIndexA];
  assign readDataB = (readIndexB == R0) ? '0 : regs[readIndexB];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: register read, write-back/load forwarding, load-use interlock.
module operand_fetch_stage #(
  parameter int NR_OF_REGS = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  cpuClock,
  input  logic                  cpuReset,
  input  logic                  stall,
  input  logic                  rdValid,
  input  logic [4:0]            rdIndexA,
  input  logic [4:0]            rdIndexB,
  input  logic [DATA_WIDTH-1:0] wbWriteData,
  input  logic [4:0]            wbWriteIndex,
  input  logic                  wbWriteEnable,
  input  logic                  wbStageLoadPending,
  input  logic                  loadDoneValid,
  input  logic [DATA_WIDTH-1:0] loadData,
  output logic [DATA_WIDTH-1:0] operandA,
  output logic [DATA_WIDTH-1:0] operandB,
  output logic                  operandsValid,
  output logic                  hazardStall,
  output logic [31:0]           hazardCycles
);
  import or1420_pkg::*;

  of_state_e state_q, state_d;
  logic [4:0] ldIdx_q, ldIdx_d;
  logic [4:0] idxA_q, idxA_d;
  logic [4:0] idxB_q, idxB_d;
  logic [DATA_WIDTH-1:0] opA_d, opB_d;
  logic valid_d;

  logic loadWrite, wbWrite, hazard;
  logic arrWe;
  logic [4:0] arrIdx, selA, selB;
  logic [DATA_WIDTH-1:0] arrData, arrA, arrB, fwdA, fwdB;

  assign loadWrite = loadDoneValid && state_q == WAIT_LOAD;
  assign wbWrite   = wbWriteEnable && !wbStageLoadPending;

  // Returning load owns the single write port over a same-cycle write-back.
  assign arrWe   = loadWrite || (wbWrite && wbWriteIndex != R0);
  assign arrIdx  = loadWrite ? ldIdx_q : wbWriteIndex;
  assign arrData = loadWrite ? loadData : wbWriteData;

  assign selA = (state_q == WAIT_LOAD) ? idxA_q : rdIndexA;
  assign selB = (state_q == WAIT_LOAD) ? idxB_q : rdIndexB;

  or1420_regArray #(
    .NR_OF_REGS(NR_OF_REGS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_regs (
    .cpuClock   (cpuClock),
    .writeEnable(arrWe),
    .writeIndex (arrIdx),
    .writeData  (arrData),
    .readIndexA (selA),
    .readIndexB (selB),
    .readDataA  (arrA),
    .readDataB  (arrB)
  );

  always_comb begin
    fwdA = arrA;
    if (selA == R0) fwdA = '0;
    else if (loadDoneValid && selA == ldIdx_q) fwdA = loadData;
    else if (wbWrite && selA == wbWriteIndex) fwdA = wbWriteData;
    fwdB = arrB;
    if (selB == R0) fwdB = '0;
    else if (loadDoneValid && selB == ldIdx_q) fwdB = loadData;
    else if (wbWrite && selB == wbWriteIndex) fwdB = wbWriteData;
  end

  assign hazard = !cpuReset && state_q == IDLE && rdValid &&
                  wbStageLoadPending && wbWriteEnable &&
                  wbWriteIndex != R0 &&
                  (rdIndexA == wbWriteIndex ||
                   rdIndexB == wbWriteIndex);

  assign hazardStall = (state_q == WAIT_LOAD) ?
                       (!cpuReset && !loadDoneValid) : hazard;

  always_comb begin
    state_d = state_q;
    ldIdx_d = ldIdx_q;
    idxA_d  = idxA_q;
    idxB_d  = idxB_q;
    opA_d   = operandA;
    opB_d   = operandB;
    valid_d = operandsValid;
    unique case (state_q)
      IDLE: begin
        if (!stall) begin
          if (hazard) begin
            state_d = WAIT_LOAD;
            ldIdx_d = wbWriteIndex;
            idxA_d  = rdIndexA;
            idxB_d  = rdIndexB;
            valid_d = 1'b0;
          end else begin
            valid_d = rdValid;
            if (rdValid) begin
              opA_d = fwdA;
              opB_d = fwdB;
            end
          end
        end
      end
      WAIT_LOAD: begin
        if (!stall && loadDoneValid) begin
          state_d = IDLE;
          valid_d = 1'b1;
          opA_d   = fwdA;
          opB_d   = fwdB;
        end
      end
    endcase
  end

  always_ff @(posedge cpuClock or posedge cpuReset) begin
    if (cpuReset) begin
      state_q       <= IDLE;
      ldIdx_q       <= '0;
      idxA_q        <= '0;
      idxB_q        <= '0;
      operandA      <= '0;
      operandB      <= '0;
      operandsValid <= 1'b0;
      hazardCycles  <= '0;
    end else begin
      state_q       <= state_d;
      ldIdx_q       <= ldIdx_d;
      idxA_q        <= idxA_d;
      idxB_q        <= idxB_d;
      operandA      <= opA_d;
      operandB      <= opB_d;
      operandsValid <= valid_d;
      if (!stall && hazardStall && hazardCycles != '1)
        hazardCycles <= hazardCycles + 32'd1;
    end
  end

endmodule
